// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: resolves register operands with writeback bypass, inserts load-use bubbles,
// and registers the execute-stage payload. Optional macro OPERAND_FETCH_BUBBLE_COUNT_EN adds a bubble counter.
module operand_fetch_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter logic [5:0]  LOAD_OPCODE    = 6'h23
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      instruction_valid,
    input  logic [DATA_WIDTH-1:0]     instruction,
    input  logic [DATA_WIDTH-1:0]     register_base_out1,
    input  logic [DATA_WIDTH-1:0]     register_base_out2,
    input  logic                      write_enabled,
    input  logic [REG_ADDR_WIDTH-1:0] register_destiny,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic                      stall,
    input  logic                      flush,
    output logic [REG_ADDR_WIDTH-1:0] register_source1,
    output logic [REG_ADDR_WIDTH-1:0] register_source2,
    output logic                      fetch_stall,
    output logic                      execute_valid,
    output logic [5:0]                execute_opcode,
    output logic [5:0]                execute_funct,
    output logic [DATA_WIDTH-1:0]     execute_operand1,
    output logic [DATA_WIDTH-1:0]     execute_operand2,
    output logic [DATA_WIDTH-1:0]     execute_immediate,
    output logic [REG_ADDR_WIDTH-1:0] execute_destiny,
    output logic                      execute_write_enabled
`ifdef OPERAND_FETCH_BUBBLE_COUNT_EN
    ,
    output logic [31:0]               bubble_count
`endif
);

    localparam int unsigned IMM_WIDTH = 16;

    logic [5:0]                opcode;
    logic [5:0]                funct;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [IMM_WIDTH-1:0]      imm16;
    logic [DATA_WIDTH-1:0]     immediate;
    logic [DATA_WIDTH-1:0]     operand1;
    logic [DATA_WIDTH-1:0]     operand2;
    logic [REG_ADDR_WIDTH-1:0] destiny;
    logic                      rt_used;
    logic                      hazard;
    logic [REG_ADDR_WIDTH-1:0] held_rs;
    logic [REG_ADDR_WIDTH-1:0] held_rt;

    assign opcode    = instruction[31:26];
    assign funct     = instruction[5:0];
    assign rs        = REG_ADDR_WIDTH'(instruction[25:21]);
    assign rt        = REG_ADDR_WIDTH'(instruction[20:16]);
    assign rd        = REG_ADDR_WIDTH'(instruction[15:11]);
    assign imm16     = instruction[IMM_WIDTH-1:0];
    assign immediate = {{(DATA_WIDTH-IMM_WIDTH){imm16[IMM_WIDTH-1]}}, imm16};

    assign register_source1 = rs;
    assign register_source2 = rt;

    // r0 reads as zero ahead of the bypass; the register file returns the pre-write value
    always_comb begin
        operand1 = register_base_out1;
        operand2 = register_base_out2;
        if (rs == '0)
            operand1 = '0;
        else if (write_enabled && (register_destiny == rs))
            operand1 = write_data;
        if (rt == '0)
            operand2 = '0;
        else if (write_enabled && (register_destiny == rt))
            operand2 = write_data;
    end

    // Stores and branches write nothing and read rt; R-type writes rd, everything else writes rt
    always_comb begin
        destiny = rt;
        rt_used = 1'b0;
        case (opcode)
            6'h00: begin
                destiny = rd;
                rt_used = 1'b1;
            end
            6'h2B, 6'h04, 6'h05: begin
                destiny = '0;
                rt_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign hazard = instruction_valid && execute_valid && (execute_opcode == LOAD_OPCODE)
                 && (execute_destiny != '0)
                 && ((execute_destiny == rs) || (rt_used && (execute_destiny == rt)));

    assign fetch_stall = stall || (hazard && !flush);

    // Execute pipeline register; a held instruction keeps absorbing writebacks to its sources
    always_ff @(posedge clock) begin
        if (reset) begin
            execute_valid         <= 1'b0;
            execute_opcode        <= '0;
            execute_funct         <= '0;
            execute_operand1      <= '0;
            execute_operand2      <= '0;
            execute_immediate     <= '0;
            execute_destiny       <= '0;
            execute_write_enabled <= 1'b0;
            held_rs               <= '0;
            held_rt               <= '0;
        end else if (flush) begin
            execute_valid <= 1'b0;
        end else if (stall) begin
            if (write_enabled && (register_destiny != '0) && (register_destiny == held_rs))
                execute_operand1 <= write_data;
            if (write_enabled && (register_destiny != '0) && (register_destiny == held_rt))
                execute_operand2 <= write_data;
        end else if (hazard) begin
            execute_valid <= 1'b0;
        end else begin
            execute_valid         <= instruction_valid;
            execute_opcode        <= opcode;
            execute_funct         <= funct;
            execute_operand1      <= operand1;
            execute_operand2      <= operand2;
            execute_immediate     <= immediate;
            execute_destiny       <= destiny;
            execute_write_enabled <= (destiny != '0);
            held_rs               <= rs;
            held_rt               <= rt;
        end
    end

`ifdef OPERAND_FETCH_BUBBLE_COUNT_EN
    // Saturating count of inserted load-use bubbles
    always_ff @(posedge clock) begin
        if (reset)
            bubble_count <= '0;
        else if (hazard && !flush && !stall && (bubble_count != 32'hFFFF_FFFF))
            bubble_count <= bubble_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Table-driven bench for operand_fetch_stage with a scoreboard queue of expected execute-stage results.
module tb_operand_fetch_stage;

    logic        clock;
    logic        reset;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] register_base_out1;
    logic [31:0] register_base_out2;
    logic        write_enabled;
    logic [4:0]  register_destiny;
    logic [31:0] write_data;
    logic        stall;
    logic        flush;
    logic [4:0]  register_source1;
    logic [4:0]  register_source2;
    logic        fetch_stall;
    logic        execute_valid;
    logic [5:0]  execute_opcode;
    logic [5:0]  execute_funct;
    logic [31:0] execute_operand1;
    logic [31:0] execute_operand2;
    logic [31:0] execute_immediate;
    logic [4:0]  execute_destiny;
    logic        execute_write_enabled;
`ifdef OPERAND_FETCH_BUBBLE_COUNT_EN
    logic [31:0] bubble_count;
`endif

    operand_fetch_stage dut (
        .clock                 (clock),
        .reset                 (reset),
        .instruction_valid     (instruction_valid),
        .instruction           (instruction),
        .register_base_out1    (register_base_out1),
        .register_base_out2    (register_base_out2),
        .write_enabled         (write_enabled),
        .register_destiny      (register_destiny),
        .write_data            (write_data),
        .stall                 (stall),
        .flush                 (flush),
        .register_source1      (register_source1),
        .register_source2      (register_source2),
        .fetch_stall           (fetch_stall),
        .execute_valid         (execute_valid),
        .execute_opcode        (execute_opcode),
        .execute_funct         (execute_funct),
        .execute_operand1      (execute_operand1),
        .execute_operand2      (execute_operand2),
        .execute_immediate     (execute_immediate),
        .execute_destiny       (execute_destiny),
        .execute_write_enabled (execute_write_enabled)
`ifdef OPERAND_FETCH_BUBBLE_COUNT_EN
        ,
        .bubble_count          (bubble_count)
`endif
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        we;
        logic [4:0]  wdst;
        logic [31:0] wdata;
        logic        stl;
        logic        fls;
        logic        fs;
        logic        ev;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        wen;
        logic        chk;
        logic [31:0] bub;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(
        input logic rst, input logic iv, input logic [31:0] instr, input logic [31:0] rd1,
        input logic [31:0] rd2, input logic we, input logic [4:0] wdst, input logic [31:0] wdata,
        input logic stl, input logic fls, input logic fs, input logic ev, input logic [5:0] op,
        input logic [5:0] fn, input logic [31:0] op1, input logic [31:0] op2, input logic [31:0] imm,
        input logic [4:0] dst, input logic wen, input logic chk, input logic [31:0] bub);
        vec_t v;
        v.rst = rst; v.iv = iv; v.instr = instr; v.rd1 = rd1; v.rd2 = rd2;
        v.we = we; v.wdst = wdst; v.wdata = wdata; v.stl = stl; v.fls = fls;
        v.fs = fs; v.ev = ev; v.op = op; v.fn = fn; v.op1 = op1; v.op2 = op2;
        v.imm = imm; v.dst = dst; v.wen = wen; v.chk = chk; v.bub = bub;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec%0d %s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    // Drive on the falling edge, check combinational outputs, then check the registered result after the edge
    task automatic apply(input vec_t v);
        vec_t e;
        logic [31:0] ins;
        @(negedge clock);
        reset              = v.rst;
        instruction_valid  = v.iv;
        instruction        = v.instr;
        register_base_out1 = v.rd1;
        register_base_out2 = v.rd2;
        write_enabled      = v.we;
        register_destiny   = v.wdst;
        write_data         = v.wdata;
        stall              = v.stl;
        flush              = v.fls;
        sb.push_back(v);
        #1;
        ins = v.instr;
        chk("fetch_stall", 32'(fetch_stall), 32'(v.fs));
        chk("register_source1", 32'(register_source1), 32'(ins[25:21]));
        chk("register_source2", 32'(register_source2), 32'(ins[20:16]));
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("execute_valid", 32'(execute_valid), 32'(e.ev));
        if (e.chk) begin
            chk("execute_opcode", 32'(execute_opcode), 32'(e.op));
            chk("execute_funct", 32'(execute_funct), 32'(e.fn));
            chk("execute_operand1", execute_operand1, e.op1);
            chk("execute_operand2", execute_operand2, e.op2);
            chk("execute_immediate", execute_immediate, e.imm);
            chk("execute_destiny", 32'(execute_destiny), 32'(e.dst));
            chk("execute_write_enabled", 32'(execute_write_enabled), 32'(e.wen));
        end
`ifdef OPERAND_FETCH_BUBBLE_COUNT_EN
        chk("bubble_count", bubble_count, e.bub);
`endif
        cur++;
    endtask

    initial begin
        reset = 1'b1; instruction_valid = 1'b0; instruction = '0;
        register_base_out1 = '0; register_base_out2 = '0; write_enabled = 1'b0;
        register_destiny = '0; write_data = '0; stall = 1'b0; flush = 1'b0;

        //            rst iv instr         rd1      rd2      we wdst wdata     stl fls  fs ev op     fn     op1       op2       imm           dst wen chk bub
        tbl.push_back(mk(1, 0, 32'h0,        32'h0,   32'h0,   0, 0,  32'h0,    0, 0,   0, 0, 6'h00, 6'h00, 32'h0,    32'h0,    32'h0,        0,  0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h012A4020, 32'd5,   32'd7,   0, 0,  32'h0,    0, 0,   0, 1, 6'h00, 6'h20, 32'd5,    32'd7,    32'h4020,     8,  1, 1, 0));
        tbl.push_back(mk(0, 1, 32'h012A4020, 32'd5,   32'd7,   1, 9,  32'h55,   0, 0,   0, 1, 6'h00, 6'h20, 32'h55,   32'd7,    32'h4020,     8,  1, 1, 0));
        tbl.push_back(mk(0, 1, 32'h000A4020, 32'h99,  32'd7,   1, 0,  32'hFF,   0, 0,   0, 1, 6'h00, 6'h20, 32'h0,    32'd7,    32'h4020,     8,  1, 1, 0));
        tbl.push_back(mk(0, 1, 32'h212BFFFC, 32'd3,   32'h22,  0, 0,  32'h0,    0, 0,   0, 1, 6'h08, 6'h3C, 32'd3,    32'h22,   32'hFFFFFFFC, 11, 1, 1, 0));
        tbl.push_back(mk(0, 1, 32'hAD2A0004, 32'h10,  32'h20,  0, 0,  32'h0,    0, 0,   0, 1, 6'h2B, 6'h04, 32'h10,   32'h20,   32'h4,        0,  0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h8D280000, 32'h100, 32'h777, 0, 0,  32'h0,    0, 0,   0, 1, 6'h23, 6'h00, 32'h100,  32'h777,  32'h0,        8,  1, 1, 0));
        tbl.push_back(mk(0, 1, 32'h01085020, 32'hAB,  32'hAB,  0, 0,  32'h0,    0, 0,   1, 0, 6'h00, 6'h00, 32'h0,    32'h0,    32'h0,        0,  0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h01085020, 32'hAB,  32'hAB,  0, 0,  32'h0,    0, 0,   0, 1, 6'h00, 6'h20, 32'hAB,   32'hAB,   32'h5020,     10, 1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h8D280000, 32'h100, 32'h777, 0, 0,  32'h0,    0, 0,   0, 1, 6'h23, 6'h00, 32'h100,  32'h777,  32'h0,        8,  1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h21280001, 32'd9,   32'd8,   0, 0,  32'h0,    0, 0,   0, 1, 6'h08, 6'h01, 32'd9,    32'd8,    32'h1,        8,  1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h8D200000, 32'h100, 32'h0,   0, 0,  32'h0,    0, 0,   0, 1, 6'h23, 6'h00, 32'h100,  32'h0,    32'h0,        0,  0, 1, 1));
        tbl.push_back(mk(0, 1, 32'h000A4020, 32'h0,   32'd7,   0, 0,  32'h0,    0, 0,   0, 1, 6'h00, 6'h20, 32'h0,    32'd7,    32'h4020,     8,  1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h012A4020, 32'd5,   32'd7,   0, 0,  32'h0,    0, 0,   0, 1, 6'h00, 6'h20, 32'd5,    32'd7,    32'h4020,     8,  1, 1, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 32'hAD2A0004, 32'hDEAD, 32'hBEEF, 1, 9, 32'h1234, 1, 0, 1, 1, 6'h00, 6'h20, 32'h1234, 32'd7,   32'h4020,     8,  1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h8D280000, 32'h100, 32'h777, 0, 0,  32'h0,    0, 0,   0, 1, 6'h23, 6'h00, 32'h100,  32'h777,  32'h0,        8,  1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h01085020, 32'hAB,  32'hAB,  0, 0,  32'h0,    0, 1,   0, 0, 6'h00, 6'h00, 32'h0,    32'h0,    32'h0,        0,  0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h012A4020, 32'd5,   32'd7,   0, 0,  32'h0,    0, 0,   0, 1, 6'h00, 6'h20, 32'd5,    32'd7,    32'h4020,     8,  1, 1, 1));
        tbl.push_back(mk(0, 1, 32'h012A4020, 32'd5,   32'd7,   0, 0,  32'h0,    1, 1,   1, 0, 6'h00, 6'h00, 32'h0,    32'h0,    32'h0,        0,  0, 0, 1));
        tbl.push_back(mk(0, 1, 32'h012A4020, 32'd5,   32'd7,   0, 0,  32'h0,    0, 0,   0, 1, 6'h00, 6'h20, 32'd5,    32'd7,    32'h4020,     8,  1, 1, 1));
        tbl.push_back(mk(1, 1, 32'h012A4020, 32'd5,   32'd7,   0, 0,  32'h0,    1, 0,   1, 0, 6'h00, 6'h00, 32'h0,    32'h0,    32'h0,        0,  0, 1, 0));
        tbl.push_back(mk(0, 0, 32'h012A4020, 32'd5,   32'd7,   0, 0,  32'h0,    0, 0,   0, 0, 6'h00, 6'h00, 32'h0,    32'h0,    32'h0,        0,  0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Held rt absorbs writebacks across a two-cycle stall
        apply(mk(0, 1, 32'h012A4020, 32'd5, 32'd7, 0, 0, 32'h0, 0, 0, 0, 1, 6'h00, 6'h20, 32'd5, 32'd7, 32'h4020, 8, 1, 1, 0));
        for (int i = 0; i < 2; i++)
            apply(mk(0, 1, 32'h8D280000, 32'h1, 32'h2, 1, 10, 32'h4321, 1, 0, 1, 1, 6'h00, 6'h20, 32'd5, 32'h4321, 32'h4020, 8, 1, 1, 0));

        // A held r0 source must not pick up a writeback addressed to r0
        apply(mk(0, 1, 32'h000A4020, 32'h99, 32'd7, 0, 0, 32'h0, 0, 0, 0, 1, 6'h00, 6'h20, 32'h0, 32'd7, 32'h4020, 8, 1, 1, 0));
        apply(mk(0, 1, 32'h000A4020, 32'h99, 32'd7, 1, 0, 32'hEE, 1, 0, 1, 1, 6'h00, 6'h20, 32'h0, 32'd7, 32'h4020, 8, 1, 1, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
